pc_branch_unit: RTL and testbench

Registered program-counter unit that generalises the combinational PcWrite logic into a sequential block.
- Owns the PC register and applies unconditional writes.
- Resolves conditional branches (LTE/GT/EQ/NE) against ALU flags that arrive a variable number of cycles later.
- Handles an exception redirect.
- Sits between the control unit, the ALU and the instruction-memory address path.

---
 rtl/pc_branch_unit.sv | 90 +++++++++
 tb/tb_pc_branch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: registered PC with flag-resolved conditional branches and exception redirect.
// Define PC_BRANCH_STATS_EN to build the taken/not-taken statistics counters.
module pc_branch_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0] EXC_VECTOR = 32'h000000FF,
  parameter int FLAG_TIMEOUT = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pc_write,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             lte_c,
  input  logic             gt_c,
  input  logic             eq_c,
  input  logic             ne_c,
  input  logic [WIDTH-1:0] br_target,
  input  logic             flag_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             pc_written,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);
  localparam int TW = $clog2(FLAG_TIMEOUT + 1);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
  typedef enum logic {RUN, WAIT_FLAGS} state_t;
  state_t state, state_nx;
  logic [3:0] mask;
  logic [WIDTH-1:0] target;
  logic [TW-1:0] tcnt;
  logic in_wait, wr, br, resolve, tmo, taken;
  always_comb begin
    in_wait = state == WAIT_FLAGS;
    taken = (mask[3] & ~gt) | (mask[2] & gt) | (mask[1] & eq) | (mask[0] & ~eq);
    wr = !in_wait && !exc_req && pc_write;
    br = !in_wait && !exc_req && !pc_write && (lte_c | gt_c | eq_c | ne_c);
    resolve = in_wait && !exc_req && flag_valid;
    tmo = in_wait && !exc_req && !flag_valid && tcnt == TW'(FLAG_TIMEOUT - 1);
    state_nx = br ? WAIT_FLAGS : (exc_req || resolve || tmo) ? RUN : state;
  end
  assign busy = state == WAIT_FLAGS;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      pc <= RESET_VECTOR;
      epc <= '0;
      pc_written <= 1'b0;
      timeout_err <= 1'b0;
      mask <= '0;
      target <= '0;
      tcnt <= '0;
    end else begin
      state <= state_nx;
      pc_written <= exc_req || wr || (resolve && taken);
      timeout_err <= tmo;
      if (exc_req) begin
        epc <= pc;
        pc <= EXC_PC;
      end else if (wr) pc <= pc_in;
      else if (resolve && taken) pc <= target;
      if (br) begin
        mask <= {lte_c, gt_c, eq_c, ne_c};
        target <= br_target;
        tcnt <= '0;
      end else if (in_wait) tcnt <= tcnt + TW'(1);
    end
  end
`ifdef PC_BRANCH_STATS_EN
  // A discarded (exception) or timed-out branch never reaches resolve, so it is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt <= '0;
      not_taken_cnt <= '0;
    end else if (resolve) begin
      if (taken && !(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
      if (!taken && !(&not_taken_cnt)) not_taken_cnt <= not_taken_cnt + CNT_W'(1);
    end
  end
`else
  assign taken_cnt = '0;
  assign not_taken_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: randomized + directed scoreboard bench for pc_branch_unit.
module tb_pc_branch_unit;
  localparam int W = 32;
  localparam int FT = 8;
  localparam int CW = 3;
  localparam logic [31:0] EXC = 32'h000000FF;
  logic clk = 0, reset_n = 0, pc_write = 0, lte_c = 0, gt_c = 0, eq_c = 0, ne_c = 0;
  logic flag_valid = 0, gt = 0, eq = 0, exc_req = 0;
  logic [W-1:0] pc_in = '0, br_target = '0;
  logic [W-1:0] pc, epc;
  logic pc_written, busy, timeout_err;
  logic [CW-1:0] taken_cnt, not_taken_cnt;
  always #5 clk = ~clk;
  pc_branch_unit #(.WIDTH(W), .RESET_VECTOR('0), .EXC_VECTOR(EXC), .FLAG_TIMEOUT(FT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .pc_write(pc_write), .pc_in(pc_in),
    .lte_c(lte_c), .gt_c(gt_c), .eq_c(eq_c), .ne_c(ne_c), .br_target(br_target),
    .flag_valid(flag_valid), .gt(gt), .eq(eq), .exc_req(exc_req),
    .pc(pc), .epc(epc), .pc_written(pc_written), .busy(busy), .timeout_err(timeout_err),
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt));
  typedef struct {
    logic [31:0] pc, epc;
    logic busy, pw, te;
    int tk, ntk;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  logic [31:0] m_pc = 0, m_epc = 0, m_tgt = 0;
  bit m_wait = 0, m_pw = 0, m_te = 0, m_lte, m_gt, m_eq, m_ne, take;
  int m_waited = 0, m_tk = 0, m_ntk = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int sat(input int v);
    return v < (1 << CW) - 1 ? v + 1 : v;
  endfunction
  task automatic model_step();
    m_pw = 0;
    m_te = 0;
    if (!reset_n) begin
      m_pc = 0; m_epc = 0; m_wait = 0; m_tk = 0; m_ntk = 0;
    end else if (exc_req) begin
      m_epc = m_pc; m_pc = EXC; m_pw = 1; m_wait = 0;
    end else if (!m_wait) begin
      if (pc_write) begin
        m_pc = pc_in; m_pw = 1;
      end else if (lte_c || gt_c || eq_c || ne_c) begin
        m_wait = 1; m_waited = 0; m_tgt = br_target;
        m_lte = lte_c; m_gt = gt_c; m_eq = eq_c; m_ne = ne_c;
      end
    end else if (flag_valid) begin
      take = (m_lte && !gt) || (m_gt && gt) || (m_eq && eq) || (m_ne && !eq);
      if (take) begin
        m_pc = m_tgt; m_pw = 1; m_tk = sat(m_tk);
      end else m_ntk = sat(m_ntk);
      m_wait = 0;
    end else begin
      m_waited++;
      if (m_waited == FT) begin
        m_te = 1; m_wait = 0;
      end
    end
  endtask
  task automatic tick();
    exp_t e;
    model_step();
    e.pc = m_pc; e.epc = m_epc; e.busy = m_wait; e.pw = m_pw; e.te = m_te;
`ifdef PC_BRANCH_STATS_EN
    e.tk = m_tk; e.ntk = m_ntk;
`else
    e.tk = 0; e.ntk = 0;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("pc", pc, mon_e.pc);
      chk("epc", epc, mon_e.epc);
      chk("busy", 32'(busy), 32'(mon_e.busy));
      chk("pc_written", 32'(pc_written), 32'(mon_e.pw));
      chk("timeout_err", 32'(timeout_err), 32'(mon_e.te));
      chk("taken_cnt", 32'(taken_cnt), 32'(mon_e.tk));
      chk("not_taken_cnt", 32'(not_taken_cnt), 32'(mon_e.ntk));
    end
  end
  task automatic idle();
    pc_write = 0; lte_c = 0; gt_c = 0; eq_c = 0; ne_c = 0;
    flag_valid = 0; gt = 0; eq = 0; exc_req = 0;
  endtask
  task automatic wr(input logic [31:0] v);
    idle(); pc_write = 1; pc_in = v; tick(); idle();
  endtask
  task automatic branch(input int c, input bit g, input bit e, input int k, input logic [31:0] tgt);
    idle();
    {lte_c, gt_c, eq_c, ne_c} = 4'b1000 >> c;
    br_target = tgt;
    tick();
    idle();
    for (int i = 1; i < k; i++) tick();
    flag_valid = 1; gt = g; eq = e;
    tick();
    idle();
  endtask
  initial begin
    #1;
    chk("reset_pc", pc, 0);
    tick(); tick();
    reset_n = 1;
    tick();
    wr(32'h40); tick(); tick();
    chk("write_hold", pc, 32'h40);
    branch(0, 1, 0, 2, 32'h80);
    chk("lte_not_taken", pc, 32'h40);
    branch(0, 0, 0, 2, 32'h80);
    chk("lte_taken", pc, 32'h80);
    wr(32'h40); branch(1, 1, 0, 2, 32'h80);
    wr(32'h40); branch(2, 0, 1, 2, 32'h80);
    wr(32'h40); branch(3, 0, 0, 2, 32'h80);
    tick();
    chk("ne_taken", pc, 32'h80);
`ifdef PC_BRANCH_STATS_EN
    chk("sweep_taken", 32'(taken_cnt), 4);
    chk("sweep_not_taken", 32'(not_taken_cnt), 1);
`endif
    wr(32'h40);
    eq_c = 1; br_target = 32'h80; tick(); idle();
    pc_write = 1; pc_in = 32'h99; lte_c = 1; br_target = 32'h55; tick();
    flag_valid = 1; eq = 1; tick(); idle(); tick();
    chk("ignored_busy", pc, 32'h80);
    wr(32'h40);
    eq_c = 1; br_target = 32'h80; tick(); idle();
    repeat (10) tick();
    chk("timeout_pc", pc, 32'h40);
    eq_c = 1; br_target = 32'h80; tick(); idle(); tick();
    exc_req = 1; tick(); idle(); tick();
    chk("exc_wait_epc", epc, 32'h40);
    chk("exc_wait_pc", pc, EXC);
    wr(32'h10);
    exc_req = 1; pc_write = 1; pc_in = 32'h33; tick(); idle(); tick();
    chk("exc_vs_write_epc", epc, 32'h10);
    chk("exc_vs_write_pc", pc, EXC);
    ne_c = 1; br_target = 32'h80; tick(); idle();
    @(negedge clk); #1;
    reset_n = 0;
    #1;
    chk("async_pc", pc, 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_epc", epc, 0);
    tick(); tick();
    reset_n = 1;
    tick();
    repeat (9) branch(1, 1, 0, 1, 32'h20);
    tick();
`ifdef PC_BRANCH_STATS_EN
    chk("sat_taken", 32'(taken_cnt), (1 << CW) - 1);
`endif
    repeat (600) begin
      exc_req = $urandom_range(0, 29) == 0;
      pc_write = $urandom_range(0, 5) == 0;
      lte_c = $urandom_range(0, 3) == 0;
      gt_c = $urandom_range(0, 3) == 0;
      eq_c = $urandom_range(0, 3) == 0;
      ne_c = $urandom_range(0, 3) == 0;
      pc_in = $urandom;
      br_target = $urandom;
      flag_valid = $urandom_range(0, 9) < 3;
      gt = 1'($urandom);
      eq = 1'($urandom);
      tick();
    end
    idle(); tick();
    @(negedge clk); #1;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
